// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// The master drives the stage status; the slave (pipe_ctrl) returns the PC and pipeline-register controls.
interface pipe_ctrl_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    logic [REG_W-1:0] i_id_rs1;
    logic [REG_W-1:0] i_id_rs2;
    logic             i_id_uses_rs1;
    logic             i_id_uses_rs2;
    logic             i_ex_memread;
    logic [REG_W-1:0] i_ex_rd;
    logic             i_ex_redirect;
    logic [XLEN-1:0]  i_ex_target;
    logic [XLEN-1:0]  i_inc_pc;
    logic             i_imem_ready;
    logic             i_halt;
    logic [XLEN-1:0]  o_next_pc;
    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_flush;
    logic             o_halted;
    logic [XLEN-1:0]  o_stall_cnt;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_memread, i_ex_rd, i_ex_redirect, i_ex_target,
               i_inc_pc, i_imem_ready, i_halt,
        input  o_next_pc, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush,
               o_halted, o_stall_cnt
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_memread, i_ex_rd, i_ex_redirect, i_ex_target,
               i_inc_pc, i_imem_ready, i_halt,
        output o_next_pc, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush,
               o_halted, o_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/fetch controller: load-use stalls, EX redirects, imem wait states and halt.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
    input logic         i_clk,
    input logic         i_rst,
    pipe_ctrl_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {RUN, IMEM_WAIT, HALT} state_t;

    state_t          state, state_nxt;
    logic            pend, pend_nxt;
    logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;

    logic            load_use_c;
    logic            pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [XLEN-1:0] next_pc;

    // x0 is never a real destination, so it can't create a hazard
    assign load_use_c = bus.i_ex_memread && (bus.i_ex_rd != '0) &&
                        ((bus.i_id_uses_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                         (bus.i_id_uses_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= RUN;
            pend     <= 1'b0;
            pend_tgt <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            pend_tgt <= pend_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        halted       = 1'b0;
        next_pc      = bus.i_inc_pc;

        case (state)
            RUN: begin
                if (bus.i_halt) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_nxt  = HALT;
                end else if (bus.i_ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (bus.i_imem_ready) begin
                        next_pc = bus.i_ex_target;
                    end else begin
                        pc_en        = 1'b0;
                        pend_nxt     = 1'b1;
                        pend_tgt_nxt = bus.i_ex_target;
                        state_nxt    = IMEM_WAIT;
                    end
                end else if (!bus.i_imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    state_nxt  = IMEM_WAIT;
                end else if (load_use_c) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            IMEM_WAIT: begin
                // a redirect arriving while waiting replaces the target and is forwarded if ready now
                if (bus.i_ex_redirect) begin
                    pend_nxt     = 1'b1;
                    pend_tgt_nxt = bus.i_ex_target;
                end
                if (!bus.i_imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else begin
                    if (bus.i_ex_redirect)
                        next_pc = bus.i_ex_target;
                    else if (pend)
                        next_pc = pend_tgt;
                    pend_nxt  = 1'b0;
                    state_nxt = RUN;
                end
            end
            HALT: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: state_nxt = RUN;
        endcase

        if (i_rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
            next_pc    = bus.i_inc_pc;
        end
    end

    assign bus.o_next_pc    = next_pc;
    assign bus.o_pc_en      = pc_en;
    assign bus.o_ifid_en    = ifid_en;
    assign bus.o_ifid_flush = ifid_flush;
    assign bus.o_idex_flush = idex_flush;
    assign bus.o_halted     = halted;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt;

    // saturating count of cycles the fetch PC was held outside HALT
    always_ff @(posedge i_clk) begin
        if (i_rst)
            stall_cnt <= '0;
        else if ((state != HALT) && !pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + XLEN'(1);
    end

    assign bus.o_stall_cnt = stall_cnt;
`else
    assign bus.o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; ctl vector is {pc_en, ifid_en, ifid_flush, idex_flush, halted}.
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cnt;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] ctl();
        return {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_flush, bus.o_halted};
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_idle(input logic [31:0] pc);
        bus.i_id_rs1      = 5'd1;
        bus.i_id_rs2      = 5'd2;
        bus.i_id_uses_rs1 = 1'b0;
        bus.i_id_uses_rs2 = 1'b0;
        bus.i_ex_memread  = 1'b0;
        bus.i_ex_rd       = 5'd0;
        bus.i_ex_redirect = 1'b0;
        bus.i_ex_target   = 32'h0;
        bus.i_inc_pc      = pc;
        bus.i_imem_ready  = 1'b1;
        bus.i_halt        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle(32'h0000_1004);
        cyc(); #1;
        checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl(), 5'b00110); end
        checks++;
        if (bus.o_next_pc !== 32'h0000_1004) begin errors++; $display("FAIL reset_next_pc: got %h exp %h", bus.o_next_pc, 32'h0000_1004); end
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.o_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.o_stall_cnt); end
        checks++;
        if (ctl() !== 5'b11000) begin errors++; $display("FAIL run_default: got %b exp %b", ctl(), 5'b11000); end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        cyc(); set_idle(32'h0000_1008);
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd5;
        bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd3;
        bus.i_id_uses_rs2 = 1'b1; bus.i_id_rs2 = 5'd5;
        #1;
        checks++;
        if (ctl() !== 5'b00010) begin errors++; $display("FAIL lu_stall: got %b exp %b", ctl(), 5'b00010); end
        exp_cnt++;
        cyc(); set_idle(32'h0000_100C);
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_next_pc !== 32'h0000_100C) begin
            errors++; $display("FAIL lu_after: got %b/%h exp %b/%h", ctl(), bus.o_next_pc, 5'b11000, 32'h0000_100C);
        end
        cyc(); set_idle(32'h0000_1010);
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd0;
        bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd0;
        #1;
        checks++;
        if (ctl() !== 5'b11000) begin errors++; $display("FAIL lu_x0: got %b exp %b", ctl(), 5'b11000); end
        cyc(); set_idle(32'h0000_1014);
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_id_uses_rs1 = 1'b0; bus.i_id_rs1 = 5'd7;
        #1;
        checks++;
        if (ctl() !== 5'b11000) begin errors++; $display("FAIL lu_unused_src: got %b exp %b", ctl(), 5'b11000); end
    endtask

    task automatic test_redirect_ready();
        cyc(); set_idle(32'h0000_1018);
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0100;
        #1;
        checks++;
        if ((ctl() & 5'b10111) !== 5'b10110 || bus.o_next_pc !== 32'h0000_0100) begin
            errors++; $display("FAIL redir_ready: got %b/%h exp %b/%h", ctl() & 5'b10111, bus.o_next_pc, 5'b10110, 32'h100);
        end
        cyc(); set_idle(32'h0000_0104);
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_next_pc !== 32'h0000_0104) begin
            errors++; $display("FAIL redir_ready_after: got %b/%h exp %b/%h", ctl(), bus.o_next_pc, 5'b11000, 32'h104);
        end
    endtask

    task automatic test_redirect_wait();
        cyc(); set_idle(32'h0000_0108);
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0200; bus.i_imem_ready = 1'b0;
        #1;
        checks++;
        if ((ctl() & 5'b10111) !== 5'b00110) begin errors++; $display("FAIL redir_wait_c0: got %b exp %b", ctl() & 5'b10111, 5'b00110); end
        exp_cnt++;
        for (int i = 0; i < 2; i++) begin
            cyc(); set_idle(32'h0000_0108); bus.i_imem_ready = 1'b0;
            #1;
            checks++;
            if (ctl() !== 5'b00010) begin errors++; $display("FAIL redir_wait_hold%0d: got %b exp %b", i, ctl(), 5'b00010); end
            exp_cnt++;
        end
        cyc(); set_idle(32'h0000_0108);
        #1;
        checks++;
        if ((ctl() & 5'b10001) !== 5'b10000 || bus.o_next_pc !== 32'h0000_0200) begin
            errors++; $display("FAIL redir_wait_release: got %b/%h exp %b/%h", ctl() & 5'b10001, bus.o_next_pc, 5'b10000, 32'h200);
        end
        cyc(); set_idle(32'h0000_0204);
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_next_pc !== 32'h0000_0204) begin
            errors++; $display("FAIL redir_wait_run: got %b/%h exp %b/%h", ctl(), bus.o_next_pc, 5'b11000, 32'h204);
        end
        checks++;
        if (bus.o_stall_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL cnt_after_wait: got %0d exp %0d", bus.o_stall_cnt, cnt_exp(exp_cnt)); end
    endtask

    task automatic test_imem_wait();
        cyc(); set_idle(32'h0000_0208); bus.i_imem_ready = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b00010) begin errors++; $display("FAIL wait_enter: got %b exp %b", ctl(), 5'b00010); end
        exp_cnt++;
        cyc(); set_idle(32'h0000_0208);
        #1;
        checks++;
        if ((ctl() & 5'b10001) !== 5'b10000 || bus.o_next_pc !== 32'h0000_0208) begin
            errors++; $display("FAIL wait_nopend: got %b/%h exp %b/%h", ctl() & 5'b10001, bus.o_next_pc, 5'b10000, 32'h208);
        end
        cyc(); set_idle(32'h0000_020C); bus.i_imem_ready = 1'b0;
        #1; exp_cnt++;
        cyc(); set_idle(32'h0000_020C); bus.i_imem_ready = 1'b0;
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0300;
        #1;
        checks++;
        if (ctl() !== 5'b00010) begin errors++; $display("FAIL wait_redir_hold: got %b exp %b", ctl(), 5'b00010); end
        exp_cnt++;
        cyc(); set_idle(32'h0000_020C);
        #1;
        checks++;
        if (bus.o_pc_en !== 1'b1 || bus.o_next_pc !== 32'h0000_0300) begin
            errors++; $display("FAIL wait_redir_late: got %b/%h exp 1/%h", bus.o_pc_en, bus.o_next_pc, 32'h300);
        end
        cyc(); set_idle(32'h0000_0304); bus.i_imem_ready = 1'b0;
        #1; exp_cnt++;
        cyc(); set_idle(32'h0000_0304);
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0400;
        #1;
        checks++;
        if (bus.o_pc_en !== 1'b1 || bus.o_next_pc !== 32'h0000_0400) begin
            errors++; $display("FAIL wait_redir_fwd: got %b/%h exp 1/%h", bus.o_pc_en, bus.o_next_pc, 32'h400);
        end
        cyc(); set_idle(32'h0000_0404);
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_stall_cnt !== cnt_exp(exp_cnt)) begin
            errors++; $display("FAIL wait_done: got %b/%0d exp %b/%0d", ctl(), bus.o_stall_cnt, 5'b11000, cnt_exp(exp_cnt));
        end
    endtask

    task automatic test_reset_mid_wait();
        cyc(); set_idle(32'h0000_0408);
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0500; bus.i_imem_ready = 1'b0;
        cyc(); set_idle(32'h0000_0408); bus.i_imem_ready = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL rst_wait_ctl: got %b exp %b", ctl(), 5'b00110); end
        cyc(); rst = 1'b0; set_idle(32'h0000_0008);
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd9;
        bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd9;
        #1;
        exp_cnt = 0;
        checks++;
        if (ctl() !== 5'b00010 || bus.o_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_wait_run: got %b/%0d exp %b/0", ctl(), bus.o_stall_cnt, 5'b00010);
        end
        exp_cnt++;
        cyc(); set_idle(32'h0000_0008);
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_next_pc !== 32'h0000_0008) begin
            errors++; $display("FAIL rst_wait_nopend: got %b/%h exp %b/%h", ctl(), bus.o_next_pc, 5'b11000, 32'h8);
        end
    endtask

    task automatic test_halt_priority();
        cyc(); set_idle(32'h0000_000C);
        bus.i_halt = 1'b1;
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0600;
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd4;
        bus.i_id_uses_rs2 = 1'b1; bus.i_id_rs2 = 5'd4;
        #1;
        checks++;
        if (ctl() !== 5'b00110 || bus.o_next_pc !== 32'h0000_000C) begin
            errors++; $display("FAIL halt_enter: got %b/%h exp %b/%h", ctl(), bus.o_next_pc, 5'b00110, 32'hC);
        end
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            cyc(); set_idle(32'h0000_0010);
            bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h0000_0700;
            bus.i_imem_ready = (i == 1);
            #1;
            checks++;
            if (ctl() !== 5'b00111) begin errors++; $display("FAIL halt_hold%0d: got %b exp %b", i, ctl(), 5'b00111); end
        end
        checks++;
        if (bus.o_stall_cnt !== cnt_exp(exp_cnt)) begin errors++; $display("FAIL halt_cnt: got %0d exp %0d", bus.o_stall_cnt, cnt_exp(exp_cnt)); end
        cyc(); set_idle(32'h0000_0000); rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL halt_rst: got %b exp %b", ctl(), 5'b00110); end
        cyc(); rst = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b11000 || bus.o_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL halt_exit: got %b/%0d exp %b/0", ctl(), bus.o_stall_cnt, 5'b11000);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst     = 1'b1;
        set_idle(32'h0);
        test_reset();
        test_load_use();
        test_redirect_ready();
        test_redirect_wait();
        test_imem_wait();
        test_reset_mid_wait();
        test_halt_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
